// File: rtl/fb_rd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fb_rd_ctrl
//  Description : Frame-buffer read controller. On a start request it reads
//                FRAME_LEN consecutive words from a synchronous memory
//                (one-cycle read latency). The starting address is
//                base_addr, and the address wraps modulo 2^ADDR_WIDTH. The
//                words are streamed to a valid/ready consumer through a
//                2-entry first-word-fall-through FIFO.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1           rising-edge clock
//    reset        in   1           synchronous active-high reset
//    start        in   1           frame read request (accepted in IDLE only)
//    base_addr    in   ADDR_WIDTH  first word address, captured on start
//    mem_rd_en    out  1           read strobe to data memory
//    mem_rd_addr  out  ADDR_WIDTH  read address (holds when mem_rd_en=0)
//    mem_rd_data  in   DATA_WIDTH  read data, valid the cycle after the strobe
//    out_data     out  DATA_WIDTH  FIFO head word
//    out_valid    out  1           out_data holds a word
//    out_ready    in   1           consumer accepts the head word
//    busy         out  1           a frame is in progress (READ or DRAIN)
//    frame_done   out  1           one-cycle pulse after the last transfer
// ============================================================================
module fb_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int FRAME_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  frame_done
);

  // The remaining-word counter must be able to hold FRAME_LEN = 2^ADDR_WIDTH.
  localparam int                CNT_W       = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  C_FRAME_LEN = CNT_W'(FRAME_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_ptr;         // next address to read
  logic [ADDR_WIDTH-1:0]   r_last_addr;   // address of the most recent read
  logic [CNT_W-1:0]        r_remaining;   // reads still to issue this frame
  logic                    r_inflight;    // a read was issued last cycle
  logic                    r_frame_done;

  logic [DATA_WIDTH-1:0]   r_fifo_mem [0:1];
  logic                    r_wr_idx;
  logic                    r_rd_idx;
  logic [1:0]              r_count;       // FIFO occupancy, 0..2

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic                    w_pop;
  logic                    w_push;
  logic [2:0]              w_level;
  logic [2:0]              w_limit;
  logic                    w_issue;
  logic [1:0]              w_count_next;

  assign w_pop  = (r_count != 2'd0) && out_ready;
  // Memory data belongs to us exactly one cycle after the strobe; the
  // inflight flag is cleared by reset so an aborted read is never captured.
  assign w_push = r_inflight;

  // A read may be issued only if, counting words already buffered and the
  // one still in flight, there is guaranteed space when its data returns.
  // A pop in this same cycle frees one slot in time for that.
  assign w_level = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_limit = 3'd2 + {2'b00, w_pop};
  assign w_issue = (r_state == S_READ) &&
                   (r_remaining != '0) &&
                   (w_level < w_limit);

  assign w_count_next = r_count + {1'b0, w_push} - {1'b0, w_pop};

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // The read strobe reacts to out_ready in the same cycle so a full FIFO
  // being drained does not cost a bubble; the address mux keeps the last
  // issued address visible while the strobe is low.
  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = w_issue ? r_ptr : r_last_addr;

  assign out_valid   = (r_count != 2'd0);
  assign out_data    = r_fifo_mem[r_rd_idx];
  assign busy        = (r_state != S_IDLE);
  assign frame_done  = r_frame_done;

  // --------------------------------------------------------------------------
  // Control FSM with address pointer and word counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_last_addr  <= '0;
      r_remaining  <= '0;
      r_inflight   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_inflight   <= w_issue;

      if (w_issue) begin
        r_last_addr <= r_ptr;
        r_ptr       <= r_ptr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - CNT_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          // start is only looked at here, so a request during a frame
          // has no effect on pointer, counter or outputs.
          if (start) begin
            r_state     <= S_READ;
            r_ptr       <= base_addr;
            r_remaining <= C_FRAME_LEN;
          end
        end

        S_READ: begin
          if (w_issue && (r_remaining == CNT_W'(1))) begin
            r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          // No reads are issued here. Once the FIFO will be empty after
          // this edge (the last outstanding read already landed), the frame
          // is complete; frame_done appears together with busy falling.
          if (w_count_next == 2'd0 && !r_inflight) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // 2-entry FWFT FIFO. The issue rule guarantees it never overflows, and
  // out_valid gating guarantees it never underflows.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_idx      <= 1'b0;
      r_rd_idx      <= 1'b0;
      r_count       <= 2'd0;
      r_fifo_mem[0] <= '0;
      r_fifo_mem[1] <= '0;
    end else begin
      if (w_push) begin
        r_fifo_mem[r_wr_idx] <= mem_rd_data;
        r_wr_idx             <= ~r_wr_idx;
      end
      if (w_pop) begin
        r_rd_idx <= ~r_rd_idx;
      end
      r_count <= w_count_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_rd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fb_rd_ctrl
//  Description : Self-checking bench for fb_rd_ctrl. Two instances share the
//                stimulus: FRAME_LEN=4 and FRAME_LEN=1. A queue-style
//                reference model predicts every output each cycle. Directed
//                frames pin the model with literal expectations, and a
//                randomized phase follows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_rd_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic          out_ready;
  logic [AW-1:0] base_addr;

  logic          en    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] rdata [2];
  logic [DW-1:0] odata [2];
  logic          ovalid[2];
  logic          obusy [2];
  logic          odone [2];

  logic [DW-1:0] mem [8];

  int n_checks = 0;
  int n_fail   = 0;

  fb_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(4)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .mem_rd_en(en[0]), .mem_rd_addr(addr[0]), .mem_rd_data(rdata[0]),
    .out_data(odata[0]), .out_valid(ovalid[0]), .out_ready(out_ready),
    .busy(obusy[0]), .frame_done(odone[0])
  );

  fb_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_LEN(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .mem_rd_en(en[1]), .mem_rd_addr(addr[1]), .mem_rd_data(rdata[1]),
    .out_data(odata[1]), .out_valid(ovalid[1]), .out_ready(out_ready),
    .busy(obusy[1]), .frame_done(odone[1])
  );

  // Synchronous memory: data one cycle after the strobe, junk otherwise so
  // a capture at the wrong time is visible.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      rdata[k] <= en[k] ? mem[addr[k]] : DW'($urandom);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Reference model: FIFO contents as a list of words, plus frame progress.
  // --------------------------------------------------------------------------
  int            m_len   [2];
  int            m_phase [2];   // 0 idle, 1 issuing reads, 2 draining
  int            m_rem   [2];
  int            m_cnt   [2];
  logic [AW-1:0] m_ptr   [2];
  logic [AW-1:0] m_last  [2];
  logic [AW-1:0] m_iaddr [2];
  bit            m_infl  [2];
  bit            m_done  [2];
  logic [DW-1:0] m_fifo  [2][4];
  bit            m_live = 1'b0;

  bit            e_valid;
  bit            e_pop;
  bit            e_en;
  logic [AW-1:0] e_addr;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      e_valid = (m_cnt[k] != 0);
      e_pop   = e_valid && out_ready;
      e_en    = (m_phase[k] == 1) && (m_rem[k] > 0) &&
                ((m_cnt[k] + int'(m_infl[k])) < (2 + int'(e_pop)));
      e_addr  = e_en ? m_ptr[k] : m_last[k];

      if (m_live) begin
        chk($sformatf("u%0d_valid", k), 32'(ovalid[k]), 32'(e_valid));
        if (e_valid)
          chk($sformatf("u%0d_data", k), 32'(odata[k]), 32'(m_fifo[k][0]));
        chk($sformatf("u%0d_rd_en", k), 32'(en[k]), 32'(e_en));
        chk($sformatf("u%0d_rd_addr", k), 32'(addr[k]), 32'(e_addr));
        chk($sformatf("u%0d_busy", k), 32'(obusy[k]), 32'(m_phase[k] != 0));
        chk($sformatf("u%0d_done", k), 32'(odone[k]), 32'(m_done[k]));
      end

      // advance to the next cycle (inputs are stable until after posedge)
      if (reset) begin
        m_phase[k] = 0; m_rem[k] = 0; m_cnt[k] = 0;
        m_ptr[k] = '0; m_last[k] = '0; m_iaddr[k] = '0;
        m_infl[k] = 1'b0; m_done[k] = 1'b0;
        m_live = 1'b1;
      end else begin
        m_done[k] = 1'b0;
        if (e_pop) begin
          for (int j = 0; j < 3; j++) m_fifo[k][j] = m_fifo[k][j+1];
          m_cnt[k]--;
        end
        if (m_infl[k] && m_cnt[k] < 4) begin
          m_fifo[k][m_cnt[k]] = mem[m_iaddr[k]];
          m_cnt[k]++;
        end
        m_infl[k]  = e_en;
        m_iaddr[k] = m_ptr[k];
        if (e_en) begin
          m_last[k] = m_ptr[k];
          m_ptr[k]  = m_ptr[k] + AW'(1);
          m_rem[k]--;
        end
        case (m_phase[k])
          0: if (start) begin
               m_phase[k] = 1; m_ptr[k] = base_addr; m_rem[k] = m_len[k];
             end
          1: if (e_en && m_rem[k] == 0) m_phase[k] = 2;
          default: if (m_cnt[k] == 0 && !m_infl[k]) begin
               m_phase[k] = 0; m_done[k] = 1'b1;
             end
        endcase
      end
    end
  end

  // One frame with out_ready=1, with literal expectations on both instances.
  task automatic directed_frame(input string tag, input logic [AW-1:0] b,
                                input logic [AW-1:0] ea [4], input logic [DW-1:0] ed [4]);
    base_addr = b; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; base_addr = AW'($urandom);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 2) chk({tag, "_early_valid"}, 32'(ovalid[0]), 0);
      if (c <= 4) begin
        chk({tag, "_en"},   32'(en[0]),   1);
        chk({tag, "_addr"}, 32'(addr[0]), 32'(ea[c-1]));
      end
      if (c >= 3 && c <= 6) begin
        chk({tag, "_valid"}, 32'(ovalid[0]), 1);
        chk({tag, "_data"},  32'(odata[0]),  32'(ed[c-3]));
      end
      if (c == 6) chk({tag, "_busy_last"}, 32'(obusy[0]), 1);
      if (c == 7) begin
        chk({tag, "_done"},  32'(odone[0]),  1);
        chk({tag, "_busy"},  32'(obusy[0]),  0);
        chk({tag, "_empty"}, 32'(ovalid[0]), 0);
      end
      if (c == 1) begin
        chk({tag, "_u1_en"},   32'(en[1]),   1);
        chk({tag, "_u1_addr"}, 32'(addr[1]), 32'(b));
      end
      if (c == 3) begin
        chk({tag, "_u1_valid"}, 32'(ovalid[1]), 1);
        chk({tag, "_u1_data"},  32'(odata[1]),  32'(ed[0]));
      end
      if (c == 4) begin
        chk({tag, "_u1_done"},  32'(odone[1]),  1);
        chk({tag, "_u1_empty"}, 32'(ovalid[1]), 0);
      end
      tick();
    end
  endtask

  logic [AW-1:0] ea [4];
  logic [DW-1:0] ed [4];
  int nrd, nx, nd;

  initial begin
    m_len[0] = 4;
    m_len[1] = 1;
    reset = 1'b1; start = 1'b1; out_ready = 1'b1; base_addr = '0;
    for (int i = 0; i < 8; i++) mem[i] = DW'(i + 1);

    // reset holds everything idle even with start asserted
    repeat (3) tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_rd_en",   32'(en[k]),     0);
      chk("rst_rd_addr", 32'(addr[k]),   0);
      chk("rst_valid",   32'(ovalid[k]), 0);
      chk("rst_data",    32'(odata[k]),  0);
      chk("rst_busy",    32'(obusy[k]),  0);
      chk("rst_done",    32'(odone[k]),  0);
    end
    tick();
    reset = 1'b0; start = 1'b0;
    tick();

    // base 0
    ea = '{3'd0, 3'd1, 3'd2, 3'd3};
    ed = '{8'h01, 8'h02, 8'h03, 8'h04};
    directed_frame("A", 3'd0, ea, ed);

    // address wrap from base 6
    ea = '{3'd6, 3'd7, 3'd0, 3'd1};
    ed = '{8'h07, 8'h08, 8'h01, 8'h02};
    directed_frame("B", 3'd6, ea, ed);

    // consumer stall in cycles 3..8
    base_addr = '0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; nrd = 0;
    for (int c = 1; c <= 14; c++) begin
      out_ready = (c >= 3 && c <= 8) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c <= 8 && en[0]) nrd++;
      if (c >= 3 && c <= 8) begin
        chk("C_stall_valid", 32'(ovalid[0]), 1);
        chk("C_stall_data",  32'(odata[0]),  32'h01);
      end
      if (c >= 9 && c <= 12) chk("C_data", 32'(odata[0]), 32'(c - 8));
      if (c == 13) chk("C_done", 32'(odone[0]), 1);
      tick();
    end
    chk("C_reads_while_stalled", 32'(nrd), 2);

    // start while busy is ignored
    base_addr = '0; out_ready = 1'b1; start = 1'b1;
    tick();
    nx = 0; nd = 0;
    for (int c = 1; c <= 10; c++) begin
      start = (c == 2);
      if (c == 2) base_addr = 3'd5;
      @(negedge clk);
      if (ovalid[0] && out_ready) nx++;
      if (odone[0]) nd++;
      tick();
    end
    start = 1'b0;
    chk("D_words", 32'(nx), 4);
    chk("D_done_pulses", 32'(nd), 1);

    // reset in cycle 4 aborts the frame
    base_addr = '0; out_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      reset = (c == 4);
      @(negedge clk);
      if (c == 5) begin
        chk("E_valid", 32'(ovalid[0]), 0);
        chk("E_busy",  32'(obusy[0]),  0);
        chk("E_rd_en", 32'(en[0]),     0);
      end
      tick();
    end
    reset = 1'b0;
    ea = '{3'd0, 3'd1, 3'd2, 3'd3};
    ed = '{8'h01, 8'h02, 8'h03, 8'h04};
    directed_frame("E_restart", 3'd0, ea, ed);

    // single-word frame from base 3 on the FRAME_LEN=1 instance
    ea = '{3'd3, 3'd4, 3'd5, 3'd6};
    ed = '{8'h04, 8'h05, 8'h06, 8'h07};
    directed_frame("F", 3'd3, ea, ed);

    // randomized phase with fresh memory contents
    reset = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 3) == 0);
      base_addr = AW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 150) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
